picc_tx_scheduler: RTL
======================

// Module: picc_tx_scheduler
// PURPOSE
//  Sequences the PICC->PCD load-modulation transmitter. Arbitrates round-robin between response
//  sources (anticollision, select, application); launches at most one response per PCD frame.
//  Launch only after the ISO14443-A frame delay time (FDT) has elapsed from PCD frame end.
//  Sits between the protocol layer and the transmitter, on the 3.39 MHz (fc/4) clock.
// PARAMETERS
//  NUM_REQ      3    number of requesters (2..8)
//  FDT_CYCLES   293  clk_in cycles from rx_frame_end to tx_start (1172/fc at fc/4)
//  WDOG_CYCLES  4096 max cycles tx_start->tx_done before abort (only with PICC_TX_WDOG_EN)
// PORTS
//  clk_in        in   1          3.39 MHz clock, single clock domain
//  rst_in        in   1          asynchronous, active-low reset
//  rx_frame_end  in   1          1-cycle pulse: PCD frame fully received
//  req_valid     in   NUM_REQ    requester i has a response pending; held until req_ready[i]
//  req_data      in   NUM_REQ*40 requester i payload, LSB first, bytes 0..4
//  req_nbytes    in   NUM_REQ*3  requester i byte count, legal 1..5
//  req_ready     out  NUM_REQ    1-cycle accept pulse to the granted requester
//  tx_data       out  40         payload to transmitter, stable from tx_start to tx_done
//  tx_nbytes     out  3          byte count to transmitter
//  tx_start      out  1          1-cycle launch pulse (transmitter is_transmit)
//  tx_done       in   1          transmitter completion pulse
//  sched_busy    out  1          high from FDT start to end of GUARD
//  done_pulse    out  1          1-cycle: response sent (or aborted)
//  done_id       out  3          requester index of the completed/aborted response
//  err_pulse     out  1          1-cycle: illegal nbytes rejected or watchdog abort
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer 0; counters 0. Reset mid-frame drops the response.
//  FSM: IDLE -> WAIT_FDT on rx_frame_end; counter loads FDT_CYCLES-1 and counts down.
//   WAIT_FDT: at count 0 -> ARB. rx_frame_end seen here restarts the FDT count.
//   ARB (1 cycle): no req_valid -> IDLE (slot missed; reqs stay pending for the next frame).
//    Otherwise grant the lowest index >= rr_ptr, wrapping; req_ready[g]=1; capture data/nbytes.
//    nbytes==0 or >5: err_pulse=1, done_id=g, no launch -> IDLE; the request is consumed.
//   LAUNCH (1 cycle): tx_start=1; rr_ptr <= g+1 mod NUM_REQ.
//   BUSY: wait for tx_done; then done_pulse=1, done_id=g -> GUARD.
//   GUARD (2 cycles): ignores rx_frame_end; -> IDLE. Total ARB->tx_start latency is 1 cycle.
//   FDT measured rx_frame_end -> tx_start = FDT_CYCLES+2 cycles.
//  rx_frame_end during ARB/LAUNCH/BUSY/GUARD is ignored. No queuing; one response per PCD frame.
//  tx_done outside BUSY is ignored. req_valid deasserted before grant: request is withdrawn.
//  tx_data/tx_nbytes hold the last captured values until the next ARB grant.
// CONFIGURATION
//  `PICC_TX_WDOG_EN defined: BUSY counts cycles; at WDOG_CYCLES without tx_done -> err_pulse=1,
//   done_pulse=1, done_id=g, -> GUARD. A late tx_done is ignored.
//  Not defined: BUSY waits indefinitely; no watchdog counter synthesized; WDOG_CYCLES unused.
// STRUCTURE
//  picc_pkg: sched_state_t enum, MAX_BYTES=5, DATA_W=40, NBYTES_W=3, FDT_DEFAULT=293.
//  Sub-module picc_rr_arbiter (NUM_REQ): req vector + rr_ptr -> one-hot grant + index.
//   Purely combinational; the pointer register stays in the scheduler.
// TESTING
//  1 req0 valid (nbytes=2, data=0x0000_00A5_5A); rx_frame_end -> tx_start exactly 295 cycles later.
//    req_ready[0] is 1 cycle before tx_start. Then tx_done -> done_pulse, done_id=0.
//  2 req0,req1,req2 all valid across 3 frames -> grants 0,1,2 in order; 4th frame with req0 only -> 0.
//  3 No req_valid at FDT expiry -> no tx_start, back to IDLE. req1 raised later waits for next frame.
//  4 req2 nbytes=6 -> err_pulse, done_id=2, req_ready[2] pulsed, no tx_start.
//    nbytes=0 gives the same response.
//  5 rx_frame_end again at cycle 100 of WAIT_FDT -> tx_start 295 cycles after the second pulse.
//    rx_frame_end during BUSY -> ignored.
//  6 rst_in low during BUSY -> outputs 0 immediately; with PICC_TX_WDOG_EN, tx_done withheld:
//    err_pulse+done_pulse at 4096 cycles after tx_start.

Source files
------------

// File: rtl/picc_pkg.sv
// rtl/picc_pkg.sv - shared types and constants for the PICC transmit scheduler
package picc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FDT,
    S_ARB,
    S_LAUNCH,
    S_BUSY,
    S_GUARD
  } sched_state_t;

  localparam int MAX_BYTES   = 5;
  localparam int DATA_W      = 40;
  localparam int NBYTES_W    = 3;
  localparam int FDT_DEFAULT = 293;
  localparam int ID_W        = 3;

  function automatic logic nbytes_legal(input logic [NBYTES_W-1:0] nb);
    return (nb != '0) && (int'(nb) <= MAX_BYTES);
  endfunction

endpackage

// File: rtl/picc_rr_arbiter.sv
// rtl/picc_rr_arbiter.sv - combinational round-robin arbiter
// Grants the lowest requesting index at or above ptr, wrapping; the pointer lives in the caller.
module picc_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  int               cand;
  logic [IDX_W-1:0] cidx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    cidx        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      cidx = IDX_W'(cand);
      if (!grant_valid && req[cidx]) begin
        grant_valid = 1'b1;
        grant[cidx] = 1'b1;
        grant_idx   = cidx;
      end
    end
  end

endmodule

// File: rtl/picc_tx_scheduler.sv
// rtl/picc_tx_scheduler.sv - FDT-timed, round-robin launch of PICC responses to the transmitter
// Optional transmit watchdog enabled by defining PICC_TX_WDOG_EN.
module picc_tx_scheduler
  import picc_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int FDT_CYCLES  = FDT_DEFAULT,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rx_frame_end,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [NUM_REQ*NBYTES_W-1:0]  req_nbytes,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]            tx_data,
  output logic [NBYTES_W-1:0]          tx_nbytes,
  output logic                         tx_start,
  input  logic                         tx_done,
  output logic                         sched_busy,
  output logic                         done_pulse,
  output logic [ID_W-1:0]              done_id,
  output logic                         err_pulse
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (FDT_CYCLES > 2) ? $clog2(FDT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FDT_LOAD   = CNT_W'(FDT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

  sched_state_t         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [IDX_W-1:0]     gnt_q, gnt_d;
  logic [DATA_W-1:0]    tx_data_q, tx_data_d;
  logic [NBYTES_W-1:0]  tx_nbytes_q, tx_nbytes_d;

  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic [DATA_W-1:0]    sel_data;
  logic [NBYTES_W-1:0]  sel_nbytes;

`ifdef PICC_TX_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_CYCLES);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES != 0);
`endif

  picc_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req         (req_valid),
    .ptr         (rr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign sel_data   = req_data[int'(grant_idx)*DATA_W +: DATA_W];
  assign sel_nbytes = req_nbytes[int'(grant_idx)*NBYTES_W +: NBYTES_W];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    tx_data_d   = tx_data_q;
    tx_nbytes_d = tx_nbytes_q;
`ifdef PICC_TX_WDOG_EN
    wdog_d      = wdog_q;
`endif
    req_ready   = '0;
    tx_start    = 1'b0;
    done_pulse  = 1'b0;
    err_pulse   = 1'b0;
    done_id     = '0;

    case (state_q)
      S_IDLE: begin
        if (rx_frame_end) begin
          state_d = S_WAIT_FDT;
          cnt_d   = FDT_LOAD;
        end
      end

      // A new PCD frame end re-arms the FDT rather than queuing a second slot.
      S_WAIT_FDT: begin
        if (rx_frame_end) begin
          cnt_d = FDT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = S_ARB;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_ARB: begin
        if (!grant_valid) begin
          state_d = S_IDLE;
        end else begin
          req_ready   = grant;
          gnt_d       = grant_idx;
          tx_data_d   = sel_data;
          tx_nbytes_d = sel_nbytes;
          if (nbytes_legal(sel_nbytes)) begin
            state_d = S_LAUNCH;
          end else begin
            err_pulse = 1'b1;
            done_id   = ID_W'(grant_idx);
            state_d   = S_IDLE;
          end
        end
      end

      S_LAUNCH: begin
        tx_start = 1'b1;
        rr_d     = (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;
        state_d  = S_BUSY;
`ifdef PICC_TX_WDOG_EN
        wdog_d   = WDOG_W'(1);
`endif
      end

      S_BUSY: begin
        if (tx_done) begin
          done_pulse = 1'b1;
          done_id    = ID_W'(gnt_q);
          state_d    = S_GUARD;
          cnt_d      = GUARD_LOAD;
        end
`ifdef PICC_TX_WDOG_EN
        else if (wdog_q == WDOG_LIMIT) begin
          err_pulse  = 1'b1;
          done_pulse = 1'b1;
          done_id    = ID_W'(gnt_q);
          state_d    = S_GUARD;
          cnt_d      = GUARD_LOAD;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end

      S_GUARD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rr_q        <= '0;
      gnt_q       <= '0;
      tx_data_q   <= '0;
      tx_nbytes_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      tx_data_q   <= tx_data_d;
      tx_nbytes_q <= tx_nbytes_d;
    end
  end

`ifdef PICC_TX_WDOG_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  assign tx_data    = tx_data_q;
  assign tx_nbytes  = tx_nbytes_q;
  assign sched_busy = (state_q != S_IDLE);

endmodule
